// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, full ALU, registered flags, req/ack load/store port.
// Latency: ALU ops retire with done one cycle after accept; loads/stores retire one cycle after mem_ack.
// Backpressure: start is ignored while busy; mem_req holds until mem_ack. Optional DATAPATH_MEMTIMEOUT_EN aborts stalled accesses.
module datapath_mc #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
`ifdef DATAPATH_MEMTIMEOUT_EN
    , parameter int TIMEOUT  = 15
`endif
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [$clog2(NREGS)-1:0]  RS1,
    input  logic [$clog2(NREGS)-1:0]  RS2,
    input  logic [$clog2(NREGS)-1:0]  RD,
    input  logic signed [NBITS-1:0]   IMM,
    input  logic [WIDTH_ALUF-1:0]     ALUControl,
    input  logic                      ALUSrc,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      RegWrite,
    input  logic                      link,
    input  logic [NBITS-1:0]          pclink,
    output logic                      busy,
    output logic                      done,
    output logic                      Zero,
    output logic                      Neg,
    output logic                      Carry,
    output logic [NBITS-1:0]          PCReg,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [NBITS-3:0]          Address,
    output logic [NBITS-1:0]          WriteData,
    input  logic [NBITS-1:0]          ReadData,
    input  logic                      mem_ack,
    output logic                      mem_err
);

    localparam int AW  = $clog2(NREGS);
    localparam int SHW = $clog2(NBITS);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MEM  = 1'b1;

    localparam logic [WIDTH_ALUF-1:0] OP_SUB  = WIDTH_ALUF'(1);
    localparam logic [WIDTH_ALUF-1:0] OP_AND  = WIDTH_ALUF'(2);
    localparam logic [WIDTH_ALUF-1:0] OP_OR   = WIDTH_ALUF'(3);
    localparam logic [WIDTH_ALUF-1:0] OP_XOR  = WIDTH_ALUF'(4);
    localparam logic [WIDTH_ALUF-1:0] OP_SLL  = WIDTH_ALUF'(5);
    localparam logic [WIDTH_ALUF-1:0] OP_SRL  = WIDTH_ALUF'(6);
    localparam logic [WIDTH_ALUF-1:0] OP_SRA  = WIDTH_ALUF'(7);
    localparam logic [WIDTH_ALUF-1:0] OP_SLT  = WIDTH_ALUF'(8);
    localparam logic [WIDTH_ALUF-1:0] OP_SLTU = WIDTH_ALUF'(9);

    logic [NBITS-1:0] rf [NREGS];
    logic [0:0]       state;

    logic [NBITS-1:0] src_a;
    logic [NBITS-1:0] src_b;
    logic [NBITS:0]   sum;
    logic [NBITS:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [NBITS-1:0] alu_res;
    logic             alu_c;

    // Captured at accept so the memory phase is independent of controller inputs
    logic [NBITS-1:0] alu_q;
    logic [AW-1:0]    rd_q;
    logic             rw_q;
    logic             lk_q;
    logic [NBITS-1:0] pcl_q;

    logic             mem_abort;
    logic [NBITS-1:0] alu_wb;
    logic [NBITS-1:0] mem_wb;

    assign src_a = rf[RS1];
    assign src_b = ALUSrc ? IMM : rf[RS2];
    assign PCReg = rf[RS1];
    assign sum   = {1'b0, src_a} + {1'b0, src_b};
    assign diff  = {1'b0, src_a} - {1'b0, src_b};
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_res = sum[NBITS-1:0];
        alu_c   = sum[NBITS];
        case (ALUControl)
            OP_SUB: begin
                alu_res = diff[NBITS-1:0];
                alu_c   = ~diff[NBITS];
            end
            OP_AND:  begin alu_res = src_a & src_b;  alu_c = 1'b0; end
            OP_OR:   begin alu_res = src_a | src_b;  alu_c = 1'b0; end
            OP_XOR:  begin alu_res = src_a ^ src_b;  alu_c = 1'b0; end
            OP_SLL:  begin alu_res = src_a << shamt; alu_c = 1'b0; end
            OP_SRL:  begin alu_res = src_a >> shamt; alu_c = 1'b0; end
            OP_SRA:  begin alu_res = $unsigned($signed(src_a) >>> shamt); alu_c = 1'b0; end
            OP_SLT: begin
                alu_res = {{(NBITS-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                alu_c   = 1'b0;
            end
            OP_SLTU: begin
                alu_res = {{(NBITS-1){1'b0}}, (src_a < src_b)};
                alu_c   = 1'b0;
            end
            default: begin
                alu_res = sum[NBITS-1:0];
                alu_c   = sum[NBITS];
            end
        endcase
    end

    assign alu_wb    = link ? pclink : alu_res;
    assign mem_wb    = lk_q ? pcl_q : (!mem_we ? ReadData : alu_q);
    assign busy      = (state == S_MEM);
    assign mem_req   = (state == S_MEM);
    assign Address   = alu_q[NBITS-1:2];

`ifdef DATAPATH_MEMTIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    // Ack arriving on the last allowed cycle still wins over the abort
    assign mem_abort = (state == S_MEM) && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if ((state == S_MEM) && !mem_ack && !mem_abort)
                wait_cnt <= wait_cnt + CW'(1);
            else
                wait_cnt <= '0;
            if (mem_abort)
                mem_err <= 1'b1;
        end
    end
`else
    assign mem_abort = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
            state     <= S_IDLE;
            done      <= 1'b0;
            Zero      <= 1'b0;
            Neg       <= 1'b0;
            Carry     <= 1'b0;
            mem_we    <= 1'b0;
            WriteData <= '0;
            alu_q     <= '0;
            rd_q      <= '0;
            rw_q      <= 1'b0;
            lk_q      <= 1'b0;
            pcl_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        Zero  <= (alu_res == '0);
                        Neg   <= alu_res[NBITS-1];
                        Carry <= alu_c;
                        if (MemRead || MemWrite) begin
                            state     <= S_MEM;
                            mem_we    <= ~MemRead;
                            alu_q     <= alu_res;
                            WriteData <= rf[RS2];
                            rd_q      <= RD;
                            rw_q      <= RegWrite;
                            lk_q      <= link;
                            pcl_q     <= pclink;
                        end else begin
                            done <= 1'b1;
                            if (RegWrite && (RD != '0))
                                rf[RD] <= alu_wb;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (rw_q && (rd_q != '0))
                            rf[rd_q] <= mem_wb;
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else if (mem_abort) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc (NBITS=8, NREGS=32); register contents observed through PCReg.
module tb_datapath_mc;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [4:0] RS1, RS2, RD;
    logic [7:0] IMM;
    logic [3:0] ALUControl;
    logic       ALUSrc, MemRead, MemWrite, RegWrite, link;
    logic [7:0] pclink;
    logic       busy, done, Zero, Neg, Carry;
    logic [7:0] PCReg;
    logic       mem_req, mem_we;
    logic [5:0] Address;
    logic [7:0] WriteData;
    logic [7:0] ReadData;
    logic       mem_ack;
    logic       mem_err;

    int tests = 0;
    int fails = 0;

    datapath_mc dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM), .ALUControl(ALUControl),
        .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .link(link), .pclink(pclink), .busy(busy), .done(done),
        .Zero(Zero), .Neg(Neg), .Carry(Carry), .PCReg(PCReg),
        .mem_req(mem_req), .mem_we(mem_we), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns one falling edge after the accept edge.
    task automatic alu_op(input logic [3:0] ctl, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [7:0] imm, input logic src);
        ALUControl = ctl; RS1 = rs1; RS2 = rs2; RD = rd; IMM = imm; ALUSrc = src;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b1; link = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0; RegWrite = 1'b0;
    endtask

    task automatic mem_op(input logic ld, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [7:0] imm, input logic rw,
                          input logic lk);
        ALUControl = 4'd0; RS1 = rs1; RS2 = rs2; RD = rd; IMM = imm; ALUSrc = 1'b1;
        MemRead = ld; MemWrite = ~ld; RegWrite = rw; link = lk; start = 1'b1;
        @(negedge clock);
        start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; link = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] r, input logic [7:0] exp);
        RS1 = r;
        #1;
        check(tag, PCReg, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; RS1 = 5'd5; RS2 = '0; RD = '0; IMM = '0;
        ALUControl = '0; ALUSrc = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        RegWrite = 1'b0; link = 1'b0; pclink = '0; ReadData = '0; mem_ack = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_memreq", mem_req, 0);
        check("rst_pcreg", PCReg, 0);
        check("rst_memerr", mem_err, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Preload r5, then assert reset mid-cycle
        alu_op(4'd0, 5'd0, 5'd0, 5'd5, 8'h33, 1'b1);
        rd_reg("preload_r5", 5'd5, 8'h33);
        #1 reset_n = 1'b0;
        #1;
        check("arst_r5", PCReg, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // ADDI r1,r0,0xFF ; ADD r2,r1,1 -> wraps to 0 with carry
        alu_op(4'd0, 5'd0, 5'd0, 5'd1, 8'hFF, 1'b1);
        check("addi_done", done, 1);
        check("addi_neg", Neg, 1);
        check("addi_carry", Carry, 0);
        check("addi_busy", busy, 0);
        alu_op(4'd0, 5'd1, 5'd0, 5'd2, 8'h01, 1'b1);
        check("add_done", done, 1);
        check("add_zero", Zero, 1);
        check("add_carry", Carry, 1);
        rd_reg("add_r2", 5'd2, 8'h00);
        @(negedge clock);
        check("done_pulse", done, 0);

        // r1 = 0x80: SRA, SUB, SLT, SLTU
        alu_op(4'd0, 5'd0, 5'd0, 5'd1, 8'h80, 1'b1);
        alu_op(4'd7, 5'd1, 5'd0, 5'd4, 8'd3, 1'b1);
        check("sra_neg", Neg, 1);
        rd_reg("sra_r4", 5'd4, 8'hF0);
        alu_op(4'd1, 5'd1, 5'd0, 5'd8, 8'd1, 1'b1);
        check("sub_carry", Carry, 1);
        check("sub_neg", Neg, 0);
        rd_reg("sub_r8", 5'd8, 8'h7F);
        alu_op(4'd8, 5'd1, 5'd0, 5'd6, 8'd1, 1'b1);
        check("slt_zero", Zero, 0);
        rd_reg("slt_r6", 5'd6, 8'h01);
        alu_op(4'd9, 5'd1, 5'd0, 5'd7, 8'd1, 1'b1);
        check("sltu_zero", Zero, 1);
        rd_reg("sltu_r7", 5'd7, 8'h00);
        alu_op(4'd4, 5'd4, 5'd8, 5'd9, 8'd0, 1'b0);
        rd_reg("xor_r9", 5'd9, 8'h8F);
        alu_op(4'd0, 5'd0, 5'd0, 5'd0, 8'h11, 1'b1);
        rd_reg("x0_alu", 5'd0, 8'h00);

        // Store r2=0x5A to r1+4, ack on the third request cycle
        alu_op(4'd0, 5'd0, 5'd0, 5'd2, 8'h5A, 1'b1);
        mem_op(1'b0, 5'd1, 5'd2, 5'd0, 8'd4, 1'b0, 1'b0);
        check("st_req1", mem_req, 1);
        check("st_busy", busy, 1);
        check("st_we", mem_we, 1);
        check("st_addr1", Address, 6'h21);
        check("st_wdata1", WriteData, 8'h5A);
        check("st_done_wait", done, 0);
        ALUControl = 4'd0; RS1 = 5'd0; RS2 = 5'd0; RD = 5'd9; IMM = 8'h77;
        ALUSrc = 1'b1; RegWrite = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0; RegWrite = 1'b0;
        check("st_req2", mem_req, 1);
        check("st_addr2", Address, 6'h21);
        check("st_wdata2", WriteData, 8'h5A);
        @(negedge clock);
        check("st_req3", mem_req, 1);
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        check("st_req_off", mem_req, 0);
        check("st_busy_off", busy, 0);
        check("st_done", done, 1);
        @(negedge clock);
        check("st_done_pulse", done, 0);
        rd_reg("st_ignored_r9", 5'd9, 8'h8F);

        // Load into x0 with link: dropped
        pclink = 8'h3C;
        mem_op(1'b1, 5'd1, 5'd0, 5'd0, 8'd0, 1'b1, 1'b1);
        check("ldx0_we", mem_we, 0);
        ReadData = 8'h99; mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        check("ldx0_done", done, 1);
        rd_reg("ldx0_x0", 5'd0, 8'h00);

        // Load r3 <- 0xA5
        mem_op(1'b1, 5'd1, 5'd0, 5'd3, 8'd0, 1'b1, 1'b0);
        check("ld_addr", Address, 6'h20);
        ReadData = 8'hA5; mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        check("ld_done", done, 1);
        rd_reg("ld_r3", 5'd3, 8'hA5);

        // Load with link into r10 writes pclink
        mem_op(1'b1, 5'd1, 5'd0, 5'd10, 8'd0, 1'b1, 1'b1);
        ReadData = 8'h11; mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        rd_reg("ldlink_r10", 5'd10, 8'h3C);

        // Stray ack in IDLE is ignored
        @(negedge clock);
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        check("stray_ack_busy", busy, 0);
        check("stray_ack_done", done, 0);

        // Reset during an access drops mem_req immediately
        mem_op(1'b1, 5'd1, 5'd0, 5'd3, 8'd0, 1'b1, 1'b0);
        check("mid_req", mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_busy", busy, 0);
        rd_reg("mid_rst_r3", 5'd3, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

`ifdef DATAPATH_MEMTIMEOUT_EN
        begin
            int n;
            ReadData = 8'h66;
            mem_op(1'b1, 5'd0, 5'd0, 5'd11, 8'd0, 1'b1, 1'b0);
            n = 0;
            while (mem_req && n < 40) begin
                n++;
                @(negedge clock);
            end
            check("to_cycles", n, 15);
            check("to_done", done, 1);
            check("to_err", mem_err, 1);
            rd_reg("to_r11", 5'd11, 8'h00);

            mem_op(1'b1, 5'd0, 5'd0, 5'd12, 8'd0, 1'b1, 1'b0);
            repeat (14) @(negedge clock);
            check("to15_req", mem_req, 1);
            mem_ack = 1'b1;
            @(negedge clock);
            mem_ack = 1'b0;
            check("to15_done", done, 1);
            check("to15_req_off", mem_req, 0);
            check("to15_err_sticky", mem_err, 1);
            rd_reg("to15_r12", 5'd12, 8'h66);
        end
`else
        check("memerr_tied", mem_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
